uart_tx_scheduler: RTL and testbench

//  Shares the single async_transmitter between two byte sources: keyboard ASCII and the terminal reply path.
//  - Keyboard bytes (pulse-strobed) are buffered in a small FIFO.
//  - Terminal replies (valid/ready) are taken directly.
//  - Grants the transmitter round-robin and sequences start/busy so no byte is lost or doubled.
//  - Sits between the PS/2 decode chain, the terminal engine and async_transmitter.

---
 rtl/console_pkg.sv | 11 +
 rtl/sync_fifo.sv | 60 ++++++
 rtl/uart_tx_scheduler.sv | 145 ++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/console_pkg.sv
// Shared console types: transmitter FSM states, byte-source ids and ASCII control codes.
package console_pkg;

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} tx_state_t;

    typedef enum logic {KBD, REP} src_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO; a push into a full FIFO is only taken
// when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned W  = 8,
    parameter int unsigned AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic          do_pop_c;
    logic          do_push_c;

    assign empty     = (level_q == '0);
    assign full      = (level_q == (AW+1)'(DEPTH));
    assign do_pop_c  = pop && !empty;
    assign do_push_c = push && (!full || do_pop_c);
    assign dout      = mem_q[rd_ptr_q];
    assign level     = level_q;

    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push_c, do_pop_c})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART transmitter between buffered keyboard bytes and
// terminal replies. Define UART_TX_CRLF_EN to follow every keyboard CR with an LF.
module uart_tx_scheduler
    import console_pkg::*;
#(
    parameter int unsigned FIFO_AW      = 3,
    parameter int unsigned BUSY_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               kbd_strobe,
    input  logic [7:0]         kbd_data,
    input  logic               rep_valid,
    input  logic [7:0]         rep_data,
    output logic               rep_ready,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    output logic               kbd_overflow,
    output logic [FIFO_AW:0]   kbd_level
);

    tx_state_t  state_q;
    src_t       last_grant_q;
    logic       tx_start_q;
    logic [7:0] tx_data_q;
    logic [3:0] to_cnt_q;
    logic       overflow_q;

    logic [7:0] fifo_dout;
    logic       fifo_empty;
    logic       fifo_full;
    logic       can_grant_c;
    logic       grant_kbd_c;
    logic       grant_rep_c;
    logic       send_lf_c;

    sync_fifo #(.W(8), .AW(FIFO_AW)) u_kbd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (kbd_strobe),
        .din   (kbd_data),
        .pop   (grant_kbd_c),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (kbd_level)
    );

    // Tie goes to whichever source did not win last time.
    always_comb begin
        can_grant_c = !rst && (state_q == IDLE) && !tx_busy && !send_lf_c;
        grant_kbd_c = can_grant_c && !fifo_empty && (!rep_valid || last_grant_q == REP);
        grant_rep_c = can_grant_c && rep_valid && !grant_kbd_c;
    end

    assign rep_ready    = grant_rep_c;
    assign tx_start     = tx_start_q;
    assign tx_data      = tx_data_q;
    assign kbd_overflow = overflow_q;

`ifdef UART_TX_CRLF_EN
    logic lf_pending_q;
    logic cr_sent_q;

    assign send_lf_c = !rst && (state_q == IDLE) && !tx_busy && lf_pending_q;

    // cr_sent_q remembers that the byte in flight is a keyboard CR.
    always_ff @(posedge clk) begin
        if (rst) begin
            lf_pending_q <= 1'b0;
            cr_sent_q    <= 1'b0;
        end else begin
            if (grant_kbd_c) begin
                cr_sent_q <= (fifo_dout == ASCII_CR);
            end else if (grant_rep_c || send_lf_c) begin
                cr_sent_q <= 1'b0;
            end
            if (state_q == START) begin
                lf_pending_q <= 1'b0;
            end else if (state_q == WAIT_DONE && !tx_busy && cr_sent_q) begin
                lf_pending_q <= 1'b1;
            end
        end
    end
`else
    assign send_lf_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= REP;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            to_cnt_q     <= 4'd0;
            overflow_q   <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            if (kbd_strobe && fifo_full && !grant_kbd_c) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (send_lf_c) begin
                        tx_data_q  <= ASCII_LF;
                        tx_start_q <= 1'b1;
                        state_q    <= START;
                    end else if (grant_kbd_c) begin
                        tx_data_q    <= fifo_dout;
                        last_grant_q <= KBD;
                        tx_start_q   <= 1'b1;
                        state_q      <= START;
                    end else if (grant_rep_c) begin
                        tx_data_q    <= rep_data;
                        last_grant_q <= REP;
                        tx_start_q   <= 1'b1;
                        state_q      <= START;
                    end
                end
                START: begin
                    to_cnt_q <= 4'd0;
                    state_q  <= WAIT_BUSY;
                end
                // A transmitter that never acknowledges is treated as having sent the byte.
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_q <= WAIT_DONE;
                    end else if (to_cnt_q == 4'(BUSY_TIMEOUT - 1)) begin
                        state_q <= IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 4'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: transmitter model, directed scenarios and a randomized
// phase scored against an in-order byte model. Honours UART_TX_CRLF_EN.
module tb_uart_tx_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       kbd_strobe = 1'b0;
    logic [7:0] kbd_data = 8'h00;
    logic       rep_valid = 1'b0;
    logic [7:0] rep_data = 8'h00;
    logic       tx_busy = 1'b0;
    logic       rep_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       kbd_overflow;
    logic [3:0] kbd_level;

    uart_tx_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .kbd_strobe   (kbd_strobe),
        .kbd_data     (kbd_data),
        .rep_valid    (rep_valid),
        .rep_data     (rep_data),
        .rep_ready    (rep_ready),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .kbd_overflow (kbd_overflow),
        .kbd_level    (kbd_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transmitter model and event log: 0 normal, 1 busy stuck high, 2 busy stuck low.
    int         cyc = 0;
    int         busy_mode = 0;
    int         rise = 0;
    int         hold = 0;
    logic       prev_busy = 1'b0;
    logic       started = 1'b0;
    logic [7:0] st_dat [1024];
    int         st_cyc [1024];
    logic       st_pb  [1024];
    int         st_n = 0;
    logic [7:0] rr_dat [1024];
    int         rr_cyc [1024];
    int         rr_n = 0;

    always begin
        @(negedge clk);
        started = (tx_start === 1'b1);
        if (started && st_n < 1024) begin
            st_dat[st_n] = tx_data;
            st_cyc[st_n] = cyc;
            st_pb[st_n]  = prev_busy;
            st_n++;
        end
        if (rep_ready === 1'b1 && rr_n < 1024) begin
            rr_dat[rr_n] = rep_data;
            rr_cyc[rr_n] = cyc;
            rr_n++;
        end
        prev_busy = tx_busy;
        @(posedge clk);
        cyc++;
        #1;
        case (busy_mode)
            1: begin tx_busy = 1'b1; rise = 0; hold = 0; end
            2: begin tx_busy = 1'b0; rise = 0; hold = 0; end
            default: begin
                if (started) begin
                    rise = 1;
                end else if (rise > 0) begin
                    rise--;
                    if (rise == 0) begin
                        tx_busy = 1'b1;
                        hold = 20;
                    end
                end else if (hold > 0) begin
                    hold--;
                    if (hold == 0) tx_busy = 1'b0;
                end else begin
                    tx_busy = 1'b0;
                end
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [7:0] b);
        kbd_strobe = 1'b1;
        kbd_data   = b;
        tick();
        kbd_strobe = 1'b0;
    endtask

    task automatic do_reset();
        kbd_strobe = 1'b0;
        rep_valid  = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_starts(input int n, input int budget, input string tag);
        int b;
        b = budget;
        while (st_n < n && b > 0) begin
            tick();
            b--;
        end
        chk(tag, 32'(st_n >= n), 32'd1);
    endtask

    int         base;
    int         rbase;
    int         n0;
    int         gap;
    int         budget;
    int         rd;
    int         rrd;
    int         rr_seen;
    logic [7:0] b8;
    logic [7:0] kq [$];

    initial begin
        // Reset state
        tick(3);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_rep_ready", 32'(rep_ready), 32'd0);
        chk("rst_overflow", 32'(kbd_overflow), 32'd0);
        chk("rst_level", 32'(kbd_level), 32'd0);
        rst = 1'b0;
        tick();

        // 1: single key latency and no duplicate start
        base = st_n;
        n0 = cyc;
        strobe(8'h41);
        chk("t1_level", 32'(kbd_level), 32'd1);
        wait_starts(base + 1, 20, "t1_wait");
        chk("t1_data", 32'(st_dat[base]), 32'h41);
        chk("t1_latency", 32'(st_cyc[base]), 32'(n0 + 2));
        tick(40);
        chk("t1_single", 32'(st_n), 32'(base + 1));

        // 2: contention after reset, keyboard wins the first tie
        busy_mode = 1;
        tick(2);
        do_reset();
        base = st_n;
        rbase = rr_n;
        strobe(8'h61);
        strobe(8'h62);
        rep_data = 8'h1B;
        rep_valid = 1'b1;
        tick(3);
        chk("t2_level", 32'(kbd_level), 32'd2);
        chk("t2_held", 32'(st_n), 32'(base));
        busy_mode = 0;
        budget = 200;
        while (st_n < base + 3 && budget > 0) begin
            tick();
            budget--;
            if (rep_valid && rr_n > rbase) rep_valid = 1'b0;
        end
        chk("t2_wait", 32'(st_n >= base + 3), 32'd1);
        chk("t2_order0", 32'(st_dat[base]), 32'h61);
        chk("t2_order1", 32'(st_dat[base + 1]), 32'h1B);
        chk("t2_order2", 32'(st_dat[base + 2]), 32'h62);
        chk("t2_ready_cnt", 32'(rr_n - rbase), 32'd1);
        chk("t2_ready_cyc", 32'(rr_cyc[rbase]), 32'(st_cyc[base + 1] - 1));

        // 3: overflow while the transmitter is stuck busy
        busy_mode = 1;
        tick(2);
        do_reset();
        base = st_n;
        for (int i = 0; i < 8; i++) strobe(8'h30 + 8'(i));
        chk("t3_full_level", 32'(kbd_level), 32'd8);
        chk("t3_full_noovf", 32'(kbd_overflow), 32'd0);
        strobe(8'h38);
        chk("t3_level", 32'(kbd_level), 32'd8);
        chk("t3_overflow", 32'(kbd_overflow), 32'd1);
        busy_mode = 0;
        wait_starts(base + 8, 400, "t3_wait");
        for (int i = 0; i < 8; i++) chk("t3_order", 32'(st_dat[base + i]), 32'h30 + 32'(i));
        tick(60);
        chk("t3_no_ninth", 32'(st_n), 32'(base + 8));
        chk("t3_sticky", 32'(kbd_overflow), 32'd1);

        // 4: busy never rises, FSM times out and moves on
        busy_mode = 2;
        tick(2);
        do_reset();
        base = st_n;
        strobe(8'h51);
        strobe(8'h52);
        wait_starts(base + 2, 100, "t4_wait");
        chk("t4_data1", 32'(st_dat[base + 1]), 32'h52);
        gap = st_cyc[base + 1] - st_cyc[base];
        chk("t4_gap", 32'(gap >= 16 && gap <= 18), 32'd1);

        // 5: reset mid-frame with the transmitter still busy
        busy_mode = 0;
        tick(2);
        do_reset();
        base = st_n;
        strobe(8'h55);
        strobe(8'h57);
        wait_starts(base + 1, 20, "t5_wait");
        tick(6);
        busy_mode = 1;
        do_reset();
        chk("t5_tx_start", 32'(tx_start), 32'd0);
        chk("t5_tx_data", 32'(tx_data), 32'd0);
        chk("t5_level", 32'(kbd_level), 32'd0);
        chk("t5_rep_ready", 32'(rep_ready), 32'd0);
        base = st_n;
        strobe(8'h56);
        tick(10);
        chk("t5_held", 32'(st_n), 32'(base));
        busy_mode = 0;
        wait_starts(base + 1, 20, "t5_resume");
        chk("t5_data", 32'(st_dat[base]), 32'h56);
        chk("t5_idle_busy", 32'(st_pb[base]), 32'd0);
        tick(40);
        chk("t5_cleared", 32'(st_n), 32'(base + 1));

        // 6: CR expansion for keyboard only
        do_reset();
        base = st_n;
        strobe(8'h0D);
`ifdef UART_TX_CRLF_EN
        wait_starts(base + 2, 80, "t6_wait");
        chk("t6_lf", 32'(st_dat[base + 1]), 32'h0A);
        tick(60);
        chk("t6_count", 32'(st_n), 32'(base + 2));
`else
        wait_starts(base + 1, 80, "t6_wait");
        tick(60);
        chk("t6_count", 32'(st_n), 32'(base + 1));
`endif
        chk("t6_cr", 32'(st_dat[base]), 32'h0D);
        base = st_n;
        rbase = rr_n;
        rep_data = 8'h0D;
        rep_valid = 1'b1;
        budget = 50;
        while (rr_n == rbase && budget > 0) begin
            tick();
            budget--;
        end
        rep_valid = 1'b0;
        chk("t6_rep_ready", 32'(rr_n), 32'(rbase + 1));
        tick(80);
        chk("t6_rep_count", 32'(st_n), 32'(base + 1));
        chk("t6_rep_cr", 32'(st_dat[base]), 32'h0D);

        // Randomized mix scored against in-order keyboard queue and granted replies
        do_reset();
        rd = st_n;
        rrd = rr_n;
        rr_seen = rr_n;
        kq.delete();
        for (int it = 0; it < 2600; it++) begin
            while (rd < st_n) begin
                while (rrd < rr_n && rr_cyc[rrd] < st_cyc[rd] - 1) begin
                    chk("rand_lost_rep", 32'(rr_cyc[rrd]), 32'(st_cyc[rd] - 1));
                    rrd++;
                end
                if (rrd < rr_n && rr_cyc[rrd] == st_cyc[rd] - 1) begin
                    chk("rand_rep", 32'(st_dat[rd]), 32'(rr_dat[rrd]));
                    rrd++;
                end else if (kq.size() == 0) begin
                    chk("rand_spurious", 32'(st_dat[rd]), 32'hFFFF);
                end else begin
                    b8 = kq.pop_front();
                    chk("rand_kbd", 32'(st_dat[rd]), 32'(b8));
                end
                chk("rand_busy_guard", 32'(st_pb[rd]), 32'd0);
                rd++;
            end
            if (rep_valid && rr_n > rr_seen) begin
                rep_valid = 1'b0;
                rr_seen = rr_n;
            end
            if (it < 2000 && $urandom_range(0, 7) == 0 && kq.size() < 6) begin
                b8 = 8'($urandom);
                if (b8 == 8'h0D) b8 = 8'h0E;
                if ($urandom_range(0, 9) == 0) b8 = 8'h0D;
                kq.push_back(b8);
`ifdef UART_TX_CRLF_EN
                if (b8 == 8'h0D) kq.push_back(8'h0A);
`endif
                kbd_strobe = 1'b1;
                kbd_data = b8;
            end else begin
                kbd_strobe = 1'b0;
            end
            if (it < 2000 && !rep_valid && $urandom_range(0, 9) == 0) begin
                rep_data = 8'($urandom);
                rep_valid = 1'b1;
            end
            tick();
        end
        chk("rand_drain", 32'(kq.size()), 32'd0);
        chk("rand_rep_done", 32'(rep_valid), 32'd0);
        chk("rand_rep_all", 32'(rrd), 32'(rr_n));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
